// File: rtl/lbm_pkg.sv
// Shared state/boundary types and index-width helpers for the lattice-Boltzmann
// control sequencer and its cell walker.
package lbm_pkg;

    typedef enum logic [4:0] {
        IDLE, INIT, MOM_LD, P_WE, DIV_START, DIV_WAIT, U_LD, U_WE, EQ_LD, EQ_WE,
        BC_WE, COLL_LD, COLL_WE, COLL_STALL, STREAM, NEXT_CELL, NEXT_STEP, DONE, ERROR
    } lbm_seq_state_t;

    typedef enum logic [1:0] {
        BND_NONE = 2'b00,
        BND_LID  = 2'b01,
        BND_WALL = 2'b10
    } bnd_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cell_w(input int nx, input int ny);
        return idx_w(nx * ny);
    endfunction

    function automatic int dir_w(input int q);
        return idx_w(q);
    endfunction

endpackage

// File: rtl/lbm_cell_walker.sv
// Raster cell walker: x/y counters, linear cell index and boundary class,
// all without any division in hardware.
module lbm_cell_walker import lbm_pkg::*; #(
    parameter int NX = 16,
    parameter int NY = 16,
    localparam int CELL_W = cell_w(NX, NY)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clr,
    input  logic              inc,
    output logic [CELL_W-1:0] cell_idx,
    output bnd_t              bnd,
    output logic              last
);
    localparam int XW = idx_w(NX);
    localparam int YW = idx_w(NY);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last;
    logic          y_last;

    assign x_last = (x == XW'(NX - 1));
    assign y_last = (y == YW'(NY - 1));
    assign last   = x_last && y_last;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x        <= '0;
            y        <= '0;
            cell_idx <= '0;
        end else if (clr || (inc && last)) begin
            x        <= '0;
            y        <= '0;
            cell_idx <= '0;
        end else if (inc) begin
            cell_idx <= cell_idx + CELL_W'(1);
            if (x_last) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // The lid row wins over the side walls at the two top corners.
    always_comb begin
        bnd = BND_NONE;
        if (y_last)
            bnd = BND_LID;
        else if ((y == '0) || (x == '0) || x_last)
            bnd = BND_WALL;
    end

endmodule

// File: rtl/lbm_sequencer.sv
// Lattice-Boltzmann control sequencer: walks every cell of an NX x NY grid through
// moment, equilibrium, boundary, collision and stream phases for max_steps steps.
module lbm_sequencer import lbm_pkg::*; #(
    parameter int NX          = 16,
    parameter int NY          = 16,
    parameter int Q           = 9,
    parameter int TIME_W      = 16,
    parameter int DIV_TIMEOUT = 64,
    localparam int CELL_W     = cell_w(NX, NY),
    localparam int DIR_W      = dir_w(Q)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] max_steps,
    input  logic              div_valid,
    input  logic [Q-1:0]      stream_ok,
    output logic [CELL_W-1:0] cell_idx,
    output logic [DIR_W-1:0]  dir_idx,
    output logic [TIME_W-1:0] step_idx,
    output logic [1:0]        bnd,
    output logic              init_we,
    output logic              mom_ld,
    output logic              p_we,
    output logic              div_start,
    output logic              u_ld,
    output logic              u_we,
    output logic              feq_ld,
    output logic              feq_we,
    output logic              bc_we,
    output logic              fout_ld,
    output logic              fout_we,
    output logic              fin_we,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int TMO_W = idx_w(DIV_TIMEOUT);

    lbm_seq_state_t    state, state_n;
    logic [TIME_W-1:0] max_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              accept;
    logic              cell_last;
    bnd_t              cell_bnd;

    assign accept = start && !abort && ((state == IDLE) || (state == DONE));
    assign bnd    = cell_bnd;

    lbm_cell_walker #(.NX(NX), .NY(NY)) u_walker (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr      (abort || accept),
        .inc      ((state == INIT) || (state == NEXT_CELL)),
        .cell_idx (cell_idx),
        .bnd      (cell_bnd),
        .last     (cell_last)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE:  if (start) state_n = INIT;
            INIT:        if (cell_last) state_n = (max_q == '0) ? DONE : MOM_LD;
            MOM_LD:      state_n = P_WE;
            P_WE:        state_n = DIV_START;
            DIV_START:   state_n = DIV_WAIT;
            DIV_WAIT: begin
                if (div_valid)
                    state_n = U_LD;
                else if (tmo_q == TMO_W'(DIV_TIMEOUT - 1))
                    state_n = ERROR;
            end
            U_LD:        state_n = U_WE;
            U_WE:        state_n = EQ_LD;
            EQ_LD:       state_n = EQ_WE;
            EQ_WE:       state_n = (cell_bnd != BND_NONE) ? BC_WE : COLL_LD;
            BC_WE:       state_n = COLL_LD;
            COLL_LD:     state_n = COLL_WE;
            COLL_WE:     state_n = COLL_STALL;
            COLL_STALL:  state_n = STREAM;
            STREAM:      if (dir_idx == DIR_W'(Q - 1)) state_n = NEXT_CELL;
            NEXT_CELL:   state_n = cell_last ? NEXT_STEP : MOM_LD;
            NEXT_STEP:   state_n = ((step_idx + TIME_W'(1)) < max_q) ? MOM_LD : DONE;
            default:     state_n = state;
        endcase
        if (abort)
            state_n = IDLE;
    end

    // Strobes are registered from the next state so each is high exactly in its state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            max_q     <= '0;
            tmo_q     <= '0;
            dir_idx   <= '0;
            step_idx  <= '0;
            init_we   <= 1'b0;
            mom_ld    <= 1'b0;
            p_we      <= 1'b0;
            div_start <= 1'b0;
            u_ld      <= 1'b0;
            u_we      <= 1'b0;
            feq_ld    <= 1'b0;
            feq_we    <= 1'b0;
            bc_we     <= 1'b0;
            fout_ld   <= 1'b0;
            fout_we   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            if (accept)
                max_q <= max_steps;
            tmo_q <= (state == DIV_WAIT) ? tmo_q + TMO_W'(1) : '0;
            if (abort || accept)
                dir_idx <= '0;
            else if (state == STREAM)
                dir_idx <= (dir_idx == DIR_W'(Q - 1)) ? '0 : dir_idx + DIR_W'(1);
            if (abort || accept)
                step_idx <= '0;
            else if (state == NEXT_STEP)
                step_idx <= step_idx + TIME_W'(1);
            init_we   <= (state_n == INIT);
            mom_ld    <= (state_n == MOM_LD);
            p_we      <= (state_n == P_WE);
            div_start <= (state_n == DIV_START);
            u_ld      <= (state_n == U_LD);
            u_we      <= (state_n == U_WE);
            feq_ld    <= (state_n == EQ_LD);
            feq_we    <= (state_n == EQ_WE);
            bc_we     <= (state_n == BC_WE);
            fout_ld   <= (state_n == COLL_LD);
            fout_we   <= (state_n == COLL_WE);
            busy      <= !(state_n inside {IDLE, DONE, ERROR});
            done      <= (state_n == DONE);
            err       <= (state_n == ERROR);
        end
    end

    assign fin_we = (state == STREAM) && stream_ok[dir_idx];

endmodule

// File: tb/tb_lbm_sequencer.sv
// Self-checking bench for lbm_sequencer on a 4x4, Q=9 grid with randomized divider
// latency and stream masks checked against a cycle-level phase model.
module tb_lbm_sequencer;
    localparam int NX = 4;
    localparam int NY = 4;
    localparam int Q = 9;
    localparam int TIME_W = 16;
    localparam int DIV_TIMEOUT = 8;
    localparam int NCELL = NX * NY;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              div_valid = 1'b0;
    logic [TIME_W-1:0] max_steps = '0;
    logic [Q-1:0]      stream_ok = '0;
    logic [3:0]        cell_idx;
    logic [3:0]        dir_idx;
    logic [TIME_W-1:0] step_idx;
    logic [1:0]        bnd;
    logic init_we, mom_ld, p_we, div_start, u_ld, u_we, feq_ld, feq_we;
    logic bc_we, fout_ld, fout_we, fin_we, busy, done, err;
    logic [11:0]       strb;

    int vec_cnt = 0;
    int err_cnt = 0;

    assign strb = {init_we, mom_ld, p_we, div_start, u_ld, u_we, feq_ld, feq_we,
                   bc_we, fout_ld, fout_we, fin_we};

    lbm_sequencer #(.NX(NX), .NY(NY), .Q(Q), .TIME_W(TIME_W), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .abort(abort), .max_steps(max_steps),
        .div_valid(div_valid), .stream_ok(stream_ok), .cell_idx(cell_idx), .dir_idx(dir_idx),
        .step_idx(step_idx), .bnd(bnd), .init_we(init_we), .mom_ld(mom_ld), .p_we(p_we),
        .div_start(div_start), .u_ld(u_ld), .u_we(u_we), .feq_ld(feq_ld), .feq_we(feq_we),
        .bc_we(bc_we), .fout_ld(fout_ld), .fout_we(fout_we), .fin_we(fin_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    // Boundary class from the grid geometry: 1 = lid (top row), 2 = wall, 0 = interior.
    function automatic int bnd_of(input int c);
        int x, y;
        x = c % NX;
        y = c / NX;
        if (y == NY - 1) return 1;
        if (y == 0 || x == 0 || x == NX - 1) return 2;
        return 0;
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        vec_cnt++;
        if ({strb, busy, done, err, cell_idx, dir_idx, step_idx} !== '0 || bnd !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset: strb=%h busy=%b done=%b err=%b cell=%0d dir=%0d step=%0d bnd=%b, required all 0, bnd=10",
                     strb, busy, done, err, cell_idx, dir_idx, step_idx, bnd);
        end
        Reset = 1'b1;
        @(negedge Clk);
        vec_cnt++;
        if ({strb, busy, done, err} !== '0) begin
            err_cnt++;
            $display("FAIL reset_release: strb=%h busy=%b done=%b err=%b, required idle", strb, busy, done, err);
        end
    endtask

    task automatic test_zero_steps();
        max_steps = '0;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            vec_cnt++;
            if (strb !== 12'h800 || cell_idx !== 4'(i) || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL zero_init i=%0d: strb=%h cell=%0d busy=%b, required strb=800 cell=%0d busy=1",
                         i, strb, cell_idx, busy, i);
            end
            @(negedge Clk);
        end
        vec_cnt++;
        if ({done, busy, err} !== 3'b100 || strb !== 12'h0 || cell_idx !== 4'd0 || step_idx !== '0) begin
            err_cnt++;
            $display("FAIL zero_done: done=%b busy=%b err=%b strb=%h cell=%0d step=%0d, required done only",
                     done, busy, err, strb, cell_idx, step_idx);
        end
    endtask

    // Full run of m steps; each cell's divider answers in DIV_WAIT cycle k (1..max_k).
    task automatic test_run(input int m, input int max_k, input bit fixed, input logic [Q-1:0] pat);
        int k, b, lst, len;
        logic [11:0] exp_s[$];
        int exp_c[$];
        int exp_d[$];
        max_steps = TIME_W'(m);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            vec_cnt++;
            if (strb !== 12'h800 || cell_idx !== 4'(i)) begin
                err_cnt++;
                $display("FAIL run_init i=%0d: strb=%h cell=%0d, required strb=800 cell=%0d", i, strb, cell_idx, i);
            end
            @(negedge Clk);
        end
        for (int s = 0; s < m; s++) begin
            for (int c = 0; c < NCELL; c++) begin
                b = bnd_of(c);
                lst = (c == NCELL - 1) ? 1 : 0;
                k = $urandom_range(max_k, 1);
                stream_ok = fixed ? pat : Q'($urandom);
                exp_s.delete(); exp_c.delete(); exp_d.delete();
                exp_s.push_back(12'h400); exp_s.push_back(12'h200); exp_s.push_back(12'h100);
                for (int w = 0; w < k; w++) exp_s.push_back(12'h000);
                exp_s.push_back(12'h080); exp_s.push_back(12'h040);
                exp_s.push_back(12'h020); exp_s.push_back(12'h010);
                if (b != 0) exp_s.push_back(12'h008);
                exp_s.push_back(12'h004); exp_s.push_back(12'h002); exp_s.push_back(12'h000);
                while (exp_c.size() < exp_s.size()) begin exp_c.push_back(c); exp_d.push_back(0); end
                for (int d = 0; d < Q; d++) begin
                    exp_s.push_back({11'h0, stream_ok[d]}); exp_c.push_back(c); exp_d.push_back(d);
                end
                exp_s.push_back(12'h000); exp_c.push_back(c); exp_d.push_back(0);
                if (lst == 1) begin exp_s.push_back(12'h000); exp_c.push_back(0); exp_d.push_back(0); end
                len = 100;
                for (int i = 0; i < 100; i++) begin
                    if (i > 0 && (mom_ld === 1'b1 || busy !== 1'b1)) begin
                        len = i;
                        break;
                    end
                    if (i < exp_s.size()) begin
                        vec_cnt++;
                        if (strb !== exp_s[i] || cell_idx !== 4'(exp_c[i]) || dir_idx !== 4'(exp_d[i]) ||
                            step_idx !== TIME_W'(s) || bnd !== 2'(bnd_of(exp_c[i])) || busy !== 1'b1) begin
                            err_cnt++;
                            $display("FAIL run_cycle s=%0d c=%0d i=%0d: strb=%h cell=%0d dir=%0d step=%0d bnd=%0d busy=%b, required strb=%h cell=%0d dir=%0d step=%0d bnd=%0d busy=1",
                                     s, c, i, strb, cell_idx, dir_idx, step_idx, bnd, busy,
                                     exp_s[i], exp_c[i], exp_d[i], s, bnd_of(exp_c[i]));
                        end
                    end
                    div_valid = (i == 2 + k);
                    @(negedge Clk);
                end
                div_valid = 1'b0;
                vec_cnt++;
                if (len != 12 + Q + ((b != 0) ? 1 : 0) + (k - 1) + lst) begin
                    err_cnt++;
                    $display("FAIL cell_latency s=%0d c=%0d k=%0d: got %0d cycles, required %0d",
                             s, c, k, len, 12 + Q + ((b != 0) ? 1 : 0) + (k - 1) + lst);
                end
            end
        end
        vec_cnt++;
        if ({done, busy, err} !== 3'b100 || strb !== 12'h0 || step_idx !== TIME_W'(m) || cell_idx !== 4'd0) begin
            err_cnt++;
            $display("FAIL run_done: done=%b busy=%b err=%b strb=%h step=%0d cell=%0d, required done=1 step=%0d cell=0",
                     done, busy, err, strb, step_idx, cell_idx, m);
        end
        @(negedge Clk);
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL done_hold: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
    endtask

    task automatic test_timeout();
        div_valid = 1'b0;
        max_steps = 16'd1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (NCELL + 2) @(negedge Clk);
        vec_cnt++;
        if (div_start !== 1'b1) begin
            err_cnt++;
            $display("FAIL tmo_div_start: div_start=%b, required 1", div_start);
        end
        @(negedge Clk);
        for (int i = 0; i < DIV_TIMEOUT; i++) begin
            vec_cnt++;
            if ({busy, err} !== 2'b10 || strb !== 12'h0) begin
                err_cnt++;
                $display("FAIL tmo_wait i=%0d: busy=%b err=%b strb=%h, required busy=1 err=0 strb=0", i, busy, err, strb);
            end
            @(negedge Clk);
        end
        vec_cnt++;
        if ({busy, done, err} !== 3'b001 || strb !== 12'h0) begin
            err_cnt++;
            $display("FAIL tmo_error: busy=%b done=%b err=%b strb=%h, required err only", busy, done, err, strb);
        end
        div_valid = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        div_valid = 1'b0;
        start = 1'b0;
        @(negedge Clk);
        vec_cnt++;
        if ({busy, done, err} !== 3'b001 || init_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL tmo_hold: busy=%b done=%b err=%b init_we=%b, required err held", busy, done, err, init_we);
        end
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        vec_cnt++;
        if ({strb, busy, done, err, cell_idx, dir_idx, step_idx} !== '0) begin
            err_cnt++;
            $display("FAIL tmo_abort: strb=%h busy=%b done=%b err=%b cell=%0d dir=%0d step=%0d, required all 0",
                     strb, busy, done, err, cell_idx, dir_idx, step_idx);
        end
    endtask

    task automatic test_abort_busy();
        bit seen;
        max_steps = 16'd2;
        stream_ok = 9'b000000100;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (5) @(negedge Clk);
        start = 1'b1;
        max_steps = '0;
        @(negedge Clk);
        start = 1'b0;
        vec_cnt++;
        if (init_we !== 1'b1 || cell_idx !== 4'd6) begin
            err_cnt++;
            $display("FAIL start_busy: init_we=%b cell=%0d, required init_we=1 cell=6", init_we, cell_idx);
        end
        div_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (fout_we === 1'b1) seen = 1'b1;
            @(negedge Clk);
        end
        div_valid = 1'b0;
        repeat (3) @(negedge Clk);
        vec_cnt++;
        if (!seen || dir_idx !== 4'd2 || fin_we !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_stream: seen=%b dir=%0d fin_we=%b busy=%b, required seen=1 dir=2 fin_we=1 busy=1",
                     seen, dir_idx, fin_we, busy);
        end
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        vec_cnt++;
        if ({strb, busy, done, err, cell_idx, dir_idx, step_idx} !== '0) begin
            err_cnt++;
            $display("FAIL stream_abort: strb=%h busy=%b done=%b err=%b cell=%0d dir=%0d step=%0d, required all 0",
                     strb, busy, done, err, cell_idx, dir_idx, step_idx);
        end
        @(negedge Clk);
        vec_cnt++;
        if ({strb, busy, done, err} !== '0) begin
            err_cnt++;
            $display("FAIL idle_hold: strb=%h busy=%b done=%b err=%b, required idle", strb, busy, done, err);
        end
    endtask

    task automatic test_abort_div();
        max_steps = 16'd1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (NCELL + 3) @(negedge Clk);
        div_valid = 1'b1;
        abort = 1'b1;
        @(negedge Clk);
        div_valid = 1'b0;
        abort = 1'b0;
        vec_cnt++;
        if ({strb, busy, done, err, cell_idx, step_idx} !== '0) begin
            err_cnt++;
            $display("FAIL abort_vs_div: strb=%h busy=%b done=%b err=%b cell=%0d step=%0d, required all 0",
                     strb, busy, done, err, cell_idx, step_idx);
        end
    endtask

    task automatic test_async_reset();
        max_steps = 16'd1;
        stream_ok = '1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        div_valid = 1'b1;
        repeat (NCELL + 14) @(negedge Clk);
        vec_cnt++;
        if (busy !== 1'b1 || fin_we !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: busy=%b fin_we=%b, required busy=1 fin_we=1", busy, fin_we);
        end
        #2 Reset = 1'b0;
        #1;
        vec_cnt++;
        if ({strb, busy, done, err, cell_idx, dir_idx, step_idx} !== '0) begin
            err_cnt++;
            $display("FAIL async_reset: strb=%h busy=%b done=%b err=%b cell=%0d dir=%0d step=%0d, required all 0",
                     strb, busy, done, err, cell_idx, dir_idx, step_idx);
        end
        div_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_zero_steps();
        test_run(2, 1, 1'b1, 9'b101010101);
        test_run(3, 4, 1'b0, '0);
        test_timeout();
        test_abort_busy();
        test_abort_div();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/lbm_sequencer.md
# lbm_sequencer

Parametrised control sequencer for the lattice-Boltzmann datapath. It generalises the fixed D2Q9 16×16 controller in four ways: a configurable grid (NX×NY), a configurable direction count Q, a runtime step count, and a start/done/abort handshake. It walks every cell through moment, equilibrium, boundary, collision and stream phases. Cell coordinates and boundary class are derived internally instead of arriving as wall inputs, and a stalled divider is detected with a timeout. It sits between the host/test harness and the p/ux/uy/feq/fin/fout memories and registers.

## Interface
- NX, 16, grid width in cells
- NY, 16, grid height in cells
- Q, 9, lattice directions per cell (stream loop length)
- TIME_W, 16, width of step counter and max_steps
- DIV_TIMEOUT, 64, max cycles spent in DIV_WAIT before error
- Derived: CELL_W = $clog2(NX*NY), DIR_W = $clog2(Q)
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled in IDLE or DONE only
- abort  in  1  synchronous; forces IDLE next cycle from any state
- max_steps  in  TIME_W  time steps to run; latched on accepted start
- div_valid  in  1  divider result ready
- stream_ok  in  Q  per-direction target valid (bit d = direction d streams in-grid)
- cell_idx  out  CELL_W  current cell, y*NX+x
- dir_idx  out  DIR_W  current stream direction
- step_idx  out  TIME_W  completed time steps
- bnd  out  2  boundary class of cell_idx: 00 interior, 01 lid, 10 wall
- init_we, mom_ld, p_we, div_start, u_ld, u_we, feq_ld, feq_we, bc_we, fout_ld, fout_we, fin_we  out  1 each  datapath strobes
- busy  out  1  high in every state except IDLE, DONE, ERROR
- done  out  1  level, high in DONE
- err  out  1  level, high in ERROR (divider timeout)

## Operation
- States: IDLE, INIT, MOM_LD, P_WE, DIV_START, DIV_WAIT, U_LD, U_WE, EQ_LD, EQ_WE, BC_WE, COLL_LD, COLL_WE, COLL_STALL, STREAM, NEXT_CELL, NEXT_STEP, DONE, ERROR.
- IDLE/DONE + start: latch max_steps, clear cell/dir/step, enter INIT.
- INIT: init_we=1 each cycle; cell_idx increments 0..NX*NY-1.
  - After the last cell: go to MOM_LD with cell 0, or to DONE if max_steps==0.
- MOM_LD → P_WE → DIV_START (div_start=1, one cycle) → DIV_WAIT.
- DIV_WAIT: on div_valid go to U_LD; after DIV_TIMEOUT cycles without div_valid go to ERROR.
- U_LD → U_WE → EQ_LD → EQ_WE.
- EQ_WE: go to BC_WE if bnd≠00, otherwise COLL_LD.
- BC_WE → COLL_LD → COLL_WE → COLL_STALL → STREAM.
- STREAM: one cycle per direction, dir_idx 0..Q-1; fin_we = stream_ok[dir_idx]. After dir Q-1, go to NEXT_CELL.
- NEXT_CELL: increment cell_idx.
  - Not the last cell: return to MOM_LD.
  - Last cell: wrap cell_idx to 0 and go to NEXT_STEP.
- NEXT_STEP: increment step_idx; if step_idx+1 < max_steps go to MOM_LD, else go to DONE.
- Boundary decode from x=cell_idx%NX and y=cell_idx/NX:
  - lid: y==NY-1
  - wall: y==0, x==0 or x==NX-1
  - lid has priority at the top corners.
- Strobe assignment:
  - mom_ld, p_we, u_ld, u_we, feq_ld, feq_we, bc_we, fout_ld, fout_we are each high exactly in their same-named state.
  - mom_ld and u_ld also carry the boundary-select meaning via bnd.
- ERROR: hold until abort (→IDLE) or Reset.
- start while busy: ignored. abort has priority over every transition, including div_valid on the same cycle.

## Timing
- Reset/abort values: state IDLE, every strobe 0, cell_idx/dir_idx/step_idx 0, busy/done/err 0.
- All outputs are Moore, decoded from registered state/counters. stream_ok is the only combinational input path: stream_ok → fin_we.
- INIT latency: NX*NY cycles.
- Per-cell latency with div_valid in the first DIV_WAIT cycle:
  - 12+Q cycles for interior cells (21 at Q=9)
  - 13+Q cycles for boundary cells
  - each extra divider wait cycle adds 1.
- Timeout: ERROR entered on the cycle after the DIV_TIMEOUT-th DIV_WAIT cycle.
- done rises the cycle after the final NEXT_STEP. It stays high until start or abort.

## Structure
- lbm_pkg holds: state enum lbm_seq_state_t, bnd_t (BND_NONE/BND_LID/BND_WALL), shared CELL_W/DIR_W helper functions.
- Sub-module lbm_cell_walker holds:
  - x/y counters with wrap
  - cell_idx generation
  - boundary decode (no division in hardware)
- The FSM, direction counter, step counter and timeout counter live in lbm_sequencer.

## Test plan
- NX=NY=4, Q=9, max_steps=0, start → 16 init_we cycles, then done=1; no mom_ld ever.
- NX=NY=4, max_steps=2, div_valid 1 cycle after div_start → 32 cell passes; step_idx ends at 2; done=1. Cell 5 (interior) takes 21 cycles; cell 0 takes 22 with bc_we=1.
- stream_ok=9'b101010101 → during STREAM, fin_we high exactly for dir_idx 0,2,4,6,8.
- Corner decode, NX=NY=4: cell 15 → bnd=01 (lid priority), cell 3 → 10, cell 5 → 00.
- div_valid held low, DIV_TIMEOUT=8 → err=1 after 8 DIV_WAIT cycles, busy=0; abort → IDLE with all outputs 0.
- abort mid-STREAM, and start asserted while busy → immediate IDLE and start ignored respectively; async Reset mid-run → all outputs 0 with no clock edge.
